// File: rtl/rk256_store.sv
`default_nettype none
// rk256_store: captures the 15 AES-256 round keys from the expander into a register file
// and serves them by round index in forward or reversed order with 1-cycle read latency.
module rk256_store #(
    parameter int NR    = 14,
    parameter int KEY_W = 128
) (
    input  logic             mclk,
    input  logic             arst_n,
    input  logic [0:KEY_W-1] rk256,
    input  logic [3:0]       rk256_count,
    input  logic             rk256_le,
    input  logic             kexp_busy,
    input  logic             flush,
    input  logic             rd_en,
    input  logic [3:0]       rd_idx,
    input  logic             rd_dec,
    output logic [0:KEY_W-1] rd_key,
    output logic             rd_valid,
    output logic             rd_err,
    output logic             keys_ready,
    output logic             fill_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
    localparam logic [3:0] NR_L    = 4'(NR);

    logic [1:0]       state_q, state_d;
    logic [NR:0]      vld_q, vld_d;
    logic [3:0]       exp_idx_q, exp_idx_d;
    logic             kexp_busy_q;
    logic [0:KEY_W-1] store_q [0:NR];
    logic [0:KEY_W-1] rd_key_q, rd_key_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic             busy_rise, busy_fall, restart, wr_en;
    logic [3:0]       rd_phys;

    assign busy_rise = kexp_busy & ~kexp_busy_q;
    assign busy_fall = ~kexp_busy & kexp_busy_q;
    assign restart   = ~flush & (busy_rise | ((state_q == S_IDLE) & rk256_le));

    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            vld_q       <= '0;
            exp_idx_q   <= '0;
            kexp_busy_q <= 1'b0;
            rd_key_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            exp_idx_q   <= exp_idx_d;
            kexp_busy_q <= kexp_busy;
            rd_key_q    <= rd_key_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // Key storage carries no reset; vld_q alone decides what is readable.
    always_ff @(posedge mclk) begin
        if (wr_en) begin
            store_q[rk256_count] <= rk256;
        end
    end

    always_comb begin
        state_d   = state_q;
        vld_d     = vld_q;
        exp_idx_d = exp_idx_q;
        wr_en     = 1'b0;
        if (flush) begin
            state_d   = S_IDLE;
            vld_d     = '0;
            exp_idx_d = '0;
        end else if (restart) begin
            // A new key set starts from a clean slate; key 0 may arrive in the same cycle.
            state_d   = S_FILL;
            vld_d     = '0;
            exp_idx_d = '0;
            if (rk256_le) begin
                if (rk256_count == 4'd0) begin
                    wr_en     = 1'b1;
                    vld_d[0]  = 1'b1;
                    exp_idx_d = 4'd1;
                end else begin
                    state_d = S_FAULT;
                end
            end
        end else begin
            case (state_q)
                S_FILL: begin
                    if (rk256_le) begin
                        if ((rk256_count == exp_idx_q) && (rk256_count <= NR_L)) begin
                            wr_en              = 1'b1;
                            vld_d[rk256_count] = 1'b1;
                            exp_idx_d          = exp_idx_q + 4'd1;
                            if (rk256_count == NR_L) begin
                                state_d = S_READY;
                            end
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                    if (busy_fall && !(wr_en && (rk256_count == NR_L))) begin
                        state_d = S_FAULT;
                    end
                end
                S_READY: begin
                    if (rk256_le) begin
                        state_d = S_FAULT;
                    end
                end
                default: ;
            endcase
        end
        if (state_d == S_FAULT) begin
            vld_d = '0;
        end
    end

    // Reads look at the pre-update valid map, with a write-first bypass of this cycle's capture.
    always_comb begin
        rd_phys    = rd_dec ? (NR_L - rd_idx) : rd_idx;
        rd_key_d   = rd_key_q;
        rd_valid_d = rd_en;
        rd_err_d   = 1'b0;
        if (rd_en) begin
            if (rd_idx > NR_L) begin
                rd_err_d = 1'b1;
                rd_key_d = '0;
            end else if (vld_q[rd_phys]) begin
                rd_key_d = store_q[rd_phys];
            end else if (wr_en && (rk256_count == rd_phys)) begin
                rd_key_d = rk256;
            end else begin
                rd_err_d = 1'b1;
                rd_key_d = '0;
            end
        end
    end

    always_comb begin
        keys_ready = (state_q == S_READY);
        fill_err   = (state_q == S_FAULT);
    end

    assign rd_key   = rd_key_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rk256_store.sv
`default_nettype none
// tb_rk256_store: table vectors, directed fill/fault/reset sequences and random traffic
// checked against a behavioural model of the key store.
module tb_rk256_store;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_READY = 2;
    localparam int M_FAULT = 3;

    logic         mclk = 1'b0;
    logic         arst_n;
    logic [0:127] rk256;
    logic [3:0]   rk256_count;
    logic         rk256_le, kexp_busy, flush, rd_en, rd_dec;
    logic [3:0]   rd_idx;
    logic [0:127] rd_key;
    logic         rd_valid, rd_err, keys_ready, fill_err;

    rk256_store #(.NR(14), .KEY_W(128)) dut (
        .mclk(mclk), .arst_n(arst_n), .rk256(rk256), .rk256_count(rk256_count),
        .rk256_le(rk256_le), .kexp_busy(kexp_busy), .flush(flush), .rd_en(rd_en),
        .rd_idx(rd_idx), .rd_dec(rd_dec), .rd_key(rd_key), .rd_valid(rd_valid),
        .rd_err(rd_err), .keys_ready(keys_ready), .fill_err(fill_err)
    );

    always #5 mclk = ~mclk;

    int total = 0;
    int bad   = 0;

    logic [127:0] fips [15];
    logic [127:0] cur  [15];

    // behavioural model state
    int           m_st;
    bit [14:0]    m_vld;
    int           m_exp;
    logic [127:0] m_store [15];
    bit           m_bq;
    logic [127:0] e_key;
    bit           e_valid, e_err;

    typedef struct {
        logic [3:0]   idx;
        bit           dec;
        logic [127:0] key;
        bit           err;
    } vec_t;
    vec_t tab [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_vld = '0; m_exp = 0; m_bq = 1'b0;
        e_key = '0; e_valid = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_eval();
        bit rise, fall, restart, cap;
        int cnt, phys, want, st0;
        st0     = m_st;
        rise    = kexp_busy && !m_bq;
        fall    = !kexp_busy && m_bq;
        cnt     = int'(rk256_count);
        restart = !flush && (rise || (st0 == M_IDLE && rk256_le));
        want    = restart ? 0 : m_exp;
        cap     = !flush && rk256_le && (restart || st0 == M_FILL) && cnt == want && cnt <= 14;
        e_valid = rd_en;
        e_err   = 1'b0;
        if (rd_en) begin
            if (rd_idx > 4'd14) begin
                e_err = 1'b1; e_key = '0;
            end else begin
                phys = rd_dec ? 14 - int'(rd_idx) : int'(rd_idx);
                if (m_vld[phys]) e_key = m_store[phys];
                else if (cap && cnt == phys) e_key = rk256;
                else begin e_err = 1'b1; e_key = '0; end
            end
        end
        if (flush) begin
            m_st = M_IDLE; m_vld = '0; m_exp = 0;
        end else begin
            if (restart) begin m_vld = '0; m_exp = 0; m_st = M_FILL; end
            if (cap) begin
                m_store[cnt] = rk256; m_vld[cnt] = 1'b1; m_exp = cnt + 1;
                if (cnt == 14) m_st = M_READY;
            end else if (rk256_le && (restart || st0 == M_FILL || st0 == M_READY)) begin
                m_st = M_FAULT;
            end
            if (fall && st0 == M_FILL && !(cap && cnt == 14)) m_st = M_FAULT;
            if (m_st == M_FAULT) m_vld = '0;
        end
        m_bq = kexp_busy;
    endtask

    task automatic step();
        model_eval();
        @(posedge mclk);
        #1;
        chk("rd_valid", rd_valid, e_valid);
        chk("rd_err", rd_err, e_err);
        chk("rd_key", rd_key, e_key);
        chk("keys_ready", keys_ready, m_st == M_READY);
        chk("fill_err", fill_err, m_st == M_FAULT);
    endtask

    task automatic feed(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rk256_le = 1'b1; rk256_count = 4'(i); rk256 = cur[i];
            step();
        end
        rk256_le = 1'b0;
    endtask

    // full key-set load; probe>=0 reads that index just before and during its capture
    task automatic fill_set(input int probe);
        kexp_busy = 1'b1; rk256_le = 1'b0; rd_en = 1'b0;
        step();
        for (int i = 0; i <= 14; i++) begin
            rk256_le = 1'b1; rk256_count = 4'(i); rk256 = cur[i];
            rd_en = (probe >= 0) && (i == probe - 1 || i == probe);
            rd_idx = 4'(probe); rd_dec = 1'b0;
            step();
            if (probe >= 0 && i == probe - 1) chk("pre_capture_err", rd_err, 1'b1);
            if (probe >= 0 && i == probe) begin
                chk("bypass_err", rd_err, 1'b0);
                chk("bypass_key", rd_key, cur[probe]);
            end
        end
        rk256_le = 1'b0; rd_en = 1'b0; kexp_busy = 1'b0;
        step();
        chk("keys_ready_after_fill", keys_ready, 1'b1);
    endtask

    task automatic apply_table();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_idx = tab[i].idx; rd_dec = tab[i].dec;
            step();
            chk("tab_valid", rd_valid, 1'b1);
            chk("tab_err", rd_err, tab[i].err);
            chk("tab_key", rd_key, tab[i].key);
        end
        rd_en = 1'b0;
        step();
    endtask

    initial begin
        fips[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
        fips[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
        fips[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
        fips[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
        fips[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
        fips[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
        fips[6]  = 128'h812c81addadf48ba24360af2fab8b464;
        fips[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
        fips[8]  = 128'h68007bacb2df331696e939e46c518d80;
        fips[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
        fips[10] = 128'hde1369676ccc5a71fa2563959674ee15;
        fips[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
        fips[12] = 128'h749c47ab18501ddae2757e4f7401905a;
        fips[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
        fips[14] = 128'hfe4890d1e6188d0b046df344706c631e;

        tab[0] = '{4'd0,  1'b0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b0};
        tab[1] = '{4'd1,  1'b0, 128'h1f352c073b6108d72d9810a30914dff4, 1'b0};
        tab[2] = '{4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0};
        tab[3] = '{4'd0,  1'b1, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0};
        tab[4] = '{4'd14, 1'b1, 128'h603deb1015ca71be2b73aef0857d7781, 1'b0};
        tab[5] = '{4'd15, 1'b1, 128'h0, 1'b1};
        tab[6] = '{4'd13, 1'b1, 128'h1f352c073b6108d72d9810a30914dff4, 1'b0};
        tab[7] = '{4'd15, 1'b0, 128'h0, 1'b1};

        arst_n = 1'b0; rk256 = '0; rk256_count = '0; rk256_le = 1'b0; kexp_busy = 1'b0;
        flush = 1'b0; rd_en = 1'b0; rd_idx = '0; rd_dec = 1'b0;
        model_reset();
        repeat (3) @(posedge mclk);
        #1;
        chk("reset_rd_key", rd_key, 128'h0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_err", rd_err, 1'b0);
        chk("reset_keys_ready", keys_ready, 1'b0);
        chk("reset_fill_err", fill_err, 1'b0);
        arst_n = 1'b1;

        // FIPS-197 fill with mid-fill probe of index 3, then forward/reverse reads
        for (int i = 0; i < 15; i++) cur[i] = fips[i];
        fill_set(3);
        apply_table();

        // second key set replaces the first
        for (int i = 0; i < 15; i++) cur[i] = {$urandom, $urandom, $urandom, $urandom};
        kexp_busy = 1'b1;
        step();
        chk("new_set_keys_ready_drop", keys_ready, 1'b0);
        rd_en = 1'b1; rd_idx = 4'd5; rd_dec = 1'b0;
        rk256_le = 1'b1; rk256_count = 4'd0; rk256 = cur[0];
        step();
        chk("old_key_unreadable", rd_err, 1'b1);
        rd_en = 1'b0;
        feed(1, 14);
        kexp_busy = 1'b0;
        step();
        chk("set2_ready", keys_ready, 1'b1);
        rd_en = 1'b1; rd_idx = 4'd7; rd_dec = 1'b1;
        step();
        chk("set2_key7", rd_key, cur[7]);
        rd_en = 1'b0;

        // out-of-order capture 0,1,3 faults; flush recovers
        for (int i = 0; i < 15; i++) cur[i] = fips[i];
        kexp_busy = 1'b1;
        step();
        feed(0, 1);
        rk256_le = 1'b1; rk256_count = 4'd3; rk256 = cur[3];
        step();
        chk("fault_fill_err", fill_err, 1'b1);
        rk256_le = 1'b0; rd_en = 1'b1; rd_idx = 4'd0; rd_dec = 1'b0;
        step();
        chk("fault_read_err", rd_err, 1'b1);
        rd_en = 1'b0; flush = 1'b1;
        step();
        chk("flush_clears_fill_err", fill_err, 1'b0);
        flush = 1'b0; kexp_busy = 1'b0;
        step();
        fill_set(-1);

        // asynchronous reset mid-fill
        kexp_busy = 1'b1;
        step();
        feed(0, 6);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_rd_key", rd_key, 128'h0);
        chk("arst_rd_valid", rd_valid, 1'b0);
        chk("arst_rd_err", rd_err, 1'b0);
        chk("arst_keys_ready", keys_ready, 1'b0);
        chk("arst_fill_err", fill_err, 1'b0);
        model_reset();
        kexp_busy = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
        arst_n = 1'b1;
        fill_set(-1);
        apply_table();

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rd_en  = ($urandom_range(0, 99) < 60);
            rd_idx = 4'($urandom_range(0, 15));
            rd_dec = 1'($urandom);
            flush  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 4) kexp_busy = ~kexp_busy;
            rk256_le = ($urandom_range(0, 99) < 60);
            rk256_count = ($urandom_range(0, 99) < 92) ? 4'(m_exp) : 4'($urandom_range(0, 15));
            rk256 = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
